// File: rtl/multicycle_ctrl_if.sv
// Instruction codes, FSM states and the memory handshake bundle.
// master: controller side (req/we out, ready in); slave: memory side.
package multicycle_ctrl_pkg;

  localparam logic [5:0] C_ADDU = 6'd1;
  localparam logic [5:0] C_SUBU = 6'd2;
  localparam logic [5:0] C_JR   = 6'd3;
  localparam logic [5:0] C_SLL  = 6'd4;
  localparam logic [5:0] C_ORI  = 6'd5;
  localparam logic [5:0] C_LW   = 6'd6;
  localparam logic [5:0] C_SW   = 6'd7;
  localparam logic [5:0] C_BEQ  = 6'd8;
  localparam logic [5:0] C_LUI  = 6'd9;
  localparam logic [5:0] C_JAL  = 6'd10;
  localparam logic [5:0] C_J    = 6'd11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

endpackage

interface multicycle_ctrl_if;
  logic imem_req_out;
  logic imem_ready_in;
  logic dmem_req_out;
  logic dmem_we_out;
  logic dmem_ready_in;

  modport master (
    output imem_req_out,
    output dmem_req_out,
    output dmem_we_out,
    input  imem_ready_in,
    input  dmem_ready_in
  );

  modport slave (
    input  imem_req_out,
    input  dmem_req_out,
    input  dmem_we_out,
    output imem_ready_in,
    output dmem_ready_in
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory waits,
// illegal-code pulse and sticky bus timeout. Optional MULTICYCLE_CTRL_PERF_EN
// adds cycle_cnt_out/retire_cnt_out. Ports: clk, reset_n, bus (memory
// handshake), instrCode_in, zero_in, datapath strobes, state_out, err_out.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_ctrl_if.master      bus,
  input  logic [5:0]             instrCode_in,
  input  logic                   zero_in,
  output logic                   pc_write_out,
  output logic [1:0]             pc_src_out,
  output logic                   ir_write_out,
  output logic                   reg_write_out,
  output logic [1:0]             reg_dst_out,
  output logic [1:0]             wd_src_out,
  output logic [2:0]             alu_op_out,
  output logic                   alu_src_b_out,
  output logic                   ext_op_out,
  output logic [2:0]             state_out,
  output logic                   illegal_out,
  output logic                   err_out
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]            cycle_cnt_out,
  output logic [31:0]            retire_cnt_out
`endif
);

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [TIMEOUT_W-1:0] wait_q;
  logic                 err_q;
  logic                 to_hit;

  logic is_addu, is_subu, is_sll, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
  logic is_r, is_exec;

  assign is_addu = instrCode_in == C_ADDU;
  assign is_subu = instrCode_in == C_SUBU;
  assign is_sll  = instrCode_in == C_SLL;
  assign is_ori  = instrCode_in == C_ORI;
  assign is_lui  = instrCode_in == C_LUI;
  assign is_lw   = instrCode_in == C_LW;
  assign is_sw   = instrCode_in == C_SW;
  assign is_beq  = instrCode_in == C_BEQ;
  assign is_j    = instrCode_in == C_J;
  assign is_jal  = instrCode_in == C_JAL;
  assign is_jr   = instrCode_in == C_JR;

  assign is_r    = is_addu | is_subu | is_sll;
  assign is_exec = is_r | is_ori | is_lui
                 | is_lw | is_sw | is_beq;

  // Fires on the wait cycle that would bring the count to the limit.
  assign to_hit = TO_EN && (wait_q == TO_LAST);

  always_comb begin
    state_d          = state_q;
    bus.imem_req_out = 1'b0;
    bus.dmem_req_out = 1'b0;
    bus.dmem_we_out  = 1'b0;
    pc_write_out     = 1'b0;
    pc_src_out       = 2'd0;
    ir_write_out     = 1'b0;
    reg_write_out    = 1'b0;
    reg_dst_out      = 2'd0;
    wd_src_out       = 2'd0;
    alu_op_out       = 3'd0;
    alu_src_b_out    = 1'b0;
    ext_op_out       = 1'b0;
    illegal_out      = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.imem_req_out = 1'b1;
        if (bus.imem_ready_in) begin
          ir_write_out = 1'b1;
          pc_write_out = 1'b1;
          state_d      = S_DECODE;
        end else if (to_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_j: begin
            pc_write_out = 1'b1;
            pc_src_out   = 2'd2;
          end
          is_jal: begin
            pc_write_out  = 1'b1;
            pc_src_out    = 2'd2;
            reg_write_out = 1'b1;
            reg_dst_out   = 2'd2;
            wd_src_out    = 2'd2;
          end
          is_jr: begin
            pc_write_out = 1'b1;
            pc_src_out   = 2'd3;
          end
          is_exec: state_d = S_EXEC;
          default: illegal_out = 1'b1;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_addu: alu_op_out = 3'd0;
          is_subu: alu_op_out = 3'd1;
          is_sll:  alu_op_out = 3'd3;
          is_ori: begin
            alu_op_out    = 3'd2;
            alu_src_b_out = 1'b1;
          end
          is_lui: begin
            alu_op_out    = 3'd4;
            alu_src_b_out = 1'b1;
          end
          is_lw | is_sw: begin
            alu_src_b_out = 1'b1;
            ext_op_out    = 1'b1;
          end
          is_beq: begin
            alu_op_out   = 3'd1;
            pc_write_out = zero_in;
            pc_src_out   = 2'd1;
          end
          default: ;
        endcase
        if (is_beq)
          state_d = S_FETCH;
        else if (is_lw | is_sw)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        bus.dmem_req_out = 1'b1;
        bus.dmem_we_out  = is_sw;
        if (bus.dmem_ready_in)
          state_d = is_sw ? S_FETCH : S_WB;
        else if (to_hit)
          state_d = S_ERROR;
      end
      S_WB: begin
        reg_write_out = 1'b1;
        reg_dst_out   = is_r ? 2'd1 : 2'd0;
        wd_src_out    = is_lw ? 2'd1 : 2'd0;
        state_d       = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q &&
          (state_d == S_FETCH || state_d == S_MEM))
        wait_q <= '0;
      else if ((state_q == S_FETCH && !bus.imem_ready_in) ||
               (state_q == S_MEM && !bus.dmem_ready_in))
        wait_q <= wait_q + 1'b1;
      if (state_d == S_ERROR)
        err_q <= 1'b1;
    end
  end

  assign state_out = state_q;
  assign err_out   = err_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;
  logic        busy;
  logic        retire;

  assign busy   = state_q != S_IDLE && state_q != S_ERROR;
  assign retire = state_d == S_FETCH &&
                  (state_q == S_DECODE || state_q == S_EXEC ||
                   state_q == S_MEM || state_q == S_WB);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (busy)
        cyc_q <= cyc_q + 32'd1;
      if (retire)
        ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt_out  = cyc_q;
  assign retire_cnt_out = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT_CYCLES=4).
// Prints CHECKS/ERRORS summary.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [5:0] code;
  logic       zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wd_src;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic       ext_op;
  logic [2:0] state;
  logic       illegal;
  logic       err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(
    .TIMEOUT_W(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(mif),
    .instrCode_in(code),
    .zero_in(zero),
    .pc_write_out(pc_write),
    .pc_src_out(pc_src),
    .ir_write_out(ir_write),
    .reg_write_out(reg_write),
    .reg_dst_out(reg_dst),
    .wd_src_out(wd_src),
    .alu_op_out(alu_op),
    .alu_src_b_out(alu_src_b),
    .ext_op_out(ext_op),
    .state_out(state),
    .illegal_out(illegal),
    .err_out(err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt_out(cycle_cnt),
    .retire_cnt_out(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] snap();
    return {pc_write, pc_src, reg_write, reg_dst,
            wd_src, alu_op, alu_src_b, ext_op};
  endfunction

  function automatic logic [12:0] mk(
    input logic pw, input logic [1:0] ps,
    input logic rw, input logic [1:0] rd,
    input logic [1:0] wd, input logic [2:0] alu,
    input logic sb, input logic ext);
    return {pw, ps, rw, rd, wd, alu, sb, ext};
  endfunction

  // Runs one instruction from FETCH back to FETCH, inserting wait
  // cycles, and snapshots strobes per state.
  task automatic run_instr(
    input  logic [5:0]  c,
    input  logic        z,
    input  int          iwait,
    input  int          dwait,
    output int          cyc,
    output logic [23:0] seq,
    output logic [12:0] dec,
    output logic [12:0] exe,
    output logic [12:0] wb,
    output logic        mem_we,
    output int          ill);
    int fw;
    int mw;
    cyc = 0; fw = 0; mw = 0; ill = 0;
    seq = '0; dec = '0; exe = '0; wb = '0;
    mem_we = 1'b0;
    code = c;
    zero = z;
    mif.imem_ready_in = (iwait == 0);
    mif.dmem_ready_in = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (illegal) ill++;
      seq = {seq[20:0], state};
      case (state)
        3'd1: fw++;
        3'd2: dec = snap();
        3'd3: exe = snap();
        3'd4: begin
          mw++;
          mem_we = mif.dmem_we_out;
        end
        3'd5: wb = snap();
        default: ;
      endcase
      cyc++;
      @(posedge clk); #1;
      mif.imem_ready_in = !(state == 3'd1 && fw < iwait);
      mif.dmem_ready_in = !(state == 3'd4 && mw < dwait);
      #1;
      if (state == 3'd1 && cyc > fw) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    code = C_ADDU;
    zero = 1'b0;
    mif.imem_ready_in = 1'b1;
    mif.dmem_ready_in = 1'b1;
    #12;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", state);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %0b want 0", err);
    end
    checks++;
    if ({mif.imem_req_out, mif.dmem_req_out,
         snap()} !== 15'd0) begin
      errors++;
      $display("FAIL reset_strobes got %h want 0",
               {mif.imem_req_out, mif.dmem_req_out, snap()});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (state !== 3'd1 || mif.imem_req_out !== 1'b1 ||
        ir_write !== 1'b1) begin
      errors++;
      $display("FAIL fetch_entry got st=%0d req=%0b irw=%0b want 1 1 1",
               state, mif.imem_req_out, ir_write);
    end
  endtask

  task automatic test_addu();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(C_ADDU, 1'b0, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (seq !== 24'h00029D) begin
      errors++;
      $display("FAIL addu_seq got %h want 00029d", seq);
    end
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL addu_cycles got %0d want 4", cyc);
    end
    checks++;
    if (w !== mk(0, 0, 1, 1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL addu_wb got %h want %h",
               w, mk(0, 0, 1, 1, 0, 0, 0, 0));
    end
    checks++;
    if (ill !== 0 || d !== 13'd0) begin
      errors++;
      $display("FAIL addu_decode got ill=%0d d=%h want 0 0", ill, d);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  codes [4];
    logic [12:0] exp_e [4];
    logic [12:0] exp_w [4];
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    codes[0] = C_SUBU; exp_e[0] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    codes[1] = C_SLL;  exp_e[1] = mk(0, 0, 0, 0, 0, 3, 0, 0);
    codes[2] = C_ORI;  exp_e[2] = mk(0, 0, 0, 0, 0, 2, 1, 0);
    codes[3] = C_LUI;  exp_e[3] = mk(0, 0, 0, 0, 0, 4, 1, 0);
    exp_w[0] = mk(0, 0, 1, 1, 0, 0, 0, 0);
    exp_w[1] = mk(0, 0, 1, 1, 0, 0, 0, 0);
    exp_w[2] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    exp_w[3] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      run_instr(codes[k], 1'b1, 0, 0, cyc, seq, d, e, w, we, ill);
      checks++;
      if (e !== exp_e[k] || cyc !== 4) begin
        errors++;
        $display("FAIL alu_exec[%0d] got %h/%0d want %h/4",
                 k, e, cyc, exp_e[k]);
      end
      checks++;
      if (w !== exp_w[k]) begin
        errors++;
        $display("FAIL alu_wb[%0d] got %h want %h", k, w, exp_w[k]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(C_LW, 1'b0, 0, 3, cyc, seq, d, e, w, we, ill);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL lw_cycles got %0d want 8", cyc);
    end
    checks++;
    if (e !== mk(0, 0, 0, 0, 0, 0, 1, 1) || we !== 1'b0) begin
      errors++;
      $display("FAIL lw_exec got %h we=%0b want %h we=0",
               e, we, mk(0, 0, 0, 0, 0, 0, 1, 1));
    end
    checks++;
    if (w !== mk(0, 0, 1, 0, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL lw_wb got %h want %h",
               w, mk(0, 0, 1, 0, 1, 0, 0, 0));
    end
    run_instr(C_LW, 1'b0, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL lw_nowait_cycles got %0d want 5", cyc);
    end
  endtask

  task automatic test_fetch_wait();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(C_ADDU, 1'b0, 3, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (cyc !== 7 || err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait got cyc=%0d err=%0b want 7 0",
               cyc, err);
    end
  endtask

  task automatic test_sw();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(C_SW, 1'b0, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (seq !== 24'h00029C || cyc !== 4) begin
      errors++;
      $display("FAIL sw_seq got %h/%0d want 00029c/4", seq, cyc);
    end
    checks++;
    if (we !== 1'b1 || w !== 13'd0) begin
      errors++;
      $display("FAIL sw_mem got we=%0b wb=%h want 1 0", we, w);
    end
  endtask

  task automatic test_beq();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(C_BEQ, 1'b1, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (e !== mk(1, 1, 0, 0, 0, 1, 0, 0) || cyc !== 3) begin
      errors++;
      $display("FAIL beq_taken got %h/%0d want %h/3",
               e, cyc, mk(1, 1, 0, 0, 0, 1, 0, 0));
    end
    run_instr(C_BEQ, 1'b0, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (e !== mk(0, 1, 0, 0, 0, 1, 0, 0) || cyc !== 3) begin
      errors++;
      $display("FAIL beq_not_taken got %h/%0d want %h/3",
               e, cyc, mk(0, 1, 0, 0, 0, 1, 0, 0));
    end
  endtask

  task automatic test_jumps();
    logic [5:0]  codes [3];
    logic [12:0] exp_d [3];
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    codes[0] = C_J;   exp_d[0] = mk(1, 2, 0, 0, 0, 0, 0, 0);
    codes[1] = C_JAL; exp_d[1] = mk(1, 2, 1, 2, 2, 0, 0, 0);
    codes[2] = C_JR;  exp_d[2] = mk(1, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      run_instr(codes[k], 1'b0, 0, 0, cyc, seq, d, e, w, we, ill);
      checks++;
      if (d !== exp_d[k] || cyc !== 2 || e !== 13'd0) begin
        errors++;
        $display("FAIL jump[%0d] got d=%h cyc=%0d e=%h want %h 2 0",
                 k, d, cyc, e, exp_d[k]);
      end
    end
  endtask

  task automatic test_illegal();
    int cyc, ill;
    logic [23:0] seq;
    logic [12:0] d, e, w;
    logic we;
    run_instr(6'h3F, 1'b1, 0, 0, cyc, seq, d, e, w, we, ill);
    checks++;
    if (ill !== 1 || cyc !== 2) begin
      errors++;
      $display("FAIL illegal_pulse got ill=%0d cyc=%0d want 1 2",
               ill, cyc);
    end
    checks++;
    if (d !== 13'd0 || state !== 3'd1) begin
      errors++;
      $display("FAIL illegal_nop got d=%h st=%0d want 0 1", d, state);
    end
  endtask

  task automatic test_reset_mid();
    code = C_LW;
    mif.imem_ready_in = 1'b1;
    mif.dmem_ready_in = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || mif.dmem_req_out !== 1'b0 ||
        reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got st=%0d dreq=%0b rw=%0b want 0 0 0",
               state, mif.dmem_req_out, reg_write);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (state !== 3'd1 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart got st=%0d rw=%0b want 1 0",
               state, reg_write);
    end
  endtask

  task automatic test_timeout();
    int n;
    code = C_ADDU;
    mif.imem_ready_in = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd7) break;
      n++;
      @(posedge clk); #2;
    end
    checks++;
    if (n !== 4 || state !== 3'd7) begin
      errors++;
      $display("FAIL timeout_waits got n=%0d st=%0d want 4 7", n, state);
    end
    checks++;
    if (err !== 1'b1 || mif.imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err got err=%0b req=%0b want 1 0",
               err, mif.imem_req_out);
    end
    mif.imem_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (state !== 3'd7 || err !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky got st=%0d err=%0b want 7 1",
               state, err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL error_reset got st=%0d err=%0b want 0 0",
               state, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL error_restart got st=%0d want 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu_ops();
    test_lw_wait();
    test_fetch_wait();
    test_sw();
    test_beq();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
